skip_sched: RTL and testbench
=============================

Name: skip_sched

Overview:
- Configuration controller for the cycle-skipping clock ring.
- Accepts a requested skip count K over a 4-phase REQ/ACK handshake and builds an evenly spread LEN-bit skip mask, one bit per clock, using accumulator (Bresenham) spreading.
- Applies the new mask to the ring only at the slot-0 boundary, so output clock pulses are never truncated. Drives the ring's MASK and E inputs.

Parameters:
- LEN, 16, ring length in slots (LEN >= 2); must match the ring instance.
- KW, 5, width of the skip-count input; must satisfy 2^KW > LEN.

Ports:
- iCLK  input  1  system clock; controller logic on posedge (ring updates on negedge).
- nRST  input  1  asynchronous active-low reset.
- REQ  input  1  configuration request, 4-phase handshake.
- KSKIP  input  KW  requested number of skipped slots per ring revolution.
- B0  input  1  slot-0 indicator from the ring (bit 0 of its one-hot selector).
- MASK  output  LEN  skip mask to the ring.
- E  output  1  ring enable (rotate + skip).
- ACK  output  1  handshake acknowledge.
- BUSY  output  1  high whenever state != IDLE.
- ERR  output  1  last request rejected.

Behaviour:
- Reset (nRST=0, asynchronous): state=IDLE, MASK=0, E=0, ACK=0, ERR=0, shadow=0, acc=0, idx=0. Any in-progress build or sync is abandoned; MASK is not partially updated.
- States: IDLE, BUILD, SYNC, ACKW.
- IDLE:
  - On a posedge with REQ=1, latch k=KSKIP.
  - If k > LEN-1: go to ACKW with ACK=1, ERR=1; MASK and E are unchanged.
  - Otherwise: ERR=0, acc=0, idx=0, go to BUILD.
- BUILD: runs exactly LEN edges, idx 0..LEN-1.
  - Each edge: s = acc + k (KW+1 bits). If s >= LEN, then shadow[idx]=1 and acc = s-LEN; else shadow[idx]=0 and acc = s.
  - On idx=LEN-1, go to SYNC.
  - KSKIP changes during BUILD are ignored.
- Shadow properties:
  - popcount(shadow) == k.
  - shadow[0] is always 0 for every legal k, so slot 0 is never skipped.
- SYNC:
  - Wait for a posedge where B0=1. On that edge: MASK = shadow, E = 1, ACK = 1, go to ACKW.
  - Wait is unbounded; BUSY stays 1 while waiting.
  - Update is glitch-free: MASK changes while the ring sits in slot 0 (B0 changes only on negedge), and slot-0 mask is 0 in both old and new masks.
- ACKW:
  - Hold ACK=1 until a posedge samples REQ=0; on that edge ACK=0 and go to IDLE.
  - A REQ still high when IDLE is re-entered is impossible by construction, since ACKW exits only on REQ=0.
- E: 0 from reset until the first successful apply, then stays 1. K=0 gives MASK=0 with E=1, so the ring rotates and nothing is skipped.
- ERR: set only by a rejected request; cleared by the next accepted one. MASK is never written on reject.
- Latency: accept edge T0, BUILD edges T1..TLEN, earliest apply/ACK at edge TLEN+1 (B0=1).
- Request while BUSY: not sampled; REQ is only examined in IDLE.

Test Plan:
- Reset: hold nRST=0 mid-run → MASK=0, E=0, ACK=0, BUSY=0, ERR=0 immediately (asynchronously), without waiting for a clock edge.
- LEN=16, KSKIP=4, B0 pulsing → after 16 BUILD edges, MASK=0x8888 applied on the first B0=1 edge with ACK=1. E=1; ACK drops one edge after REQ=0. Ring oCLK then skips 4 of every 16 pulses.
- KSKIP=8 → MASK=0xAAAA. KSKIP=15 → MASK=0xFFFE. KSKIP=0 → MASK=0x0000 with E=1. Popcount equals K in every case.
- KSKIP=16 after a prior K=4 config → ACK=1, ERR=1, BUSY=1 until REQ drops, MASK stays 0x8888; a following KSKIP=2 clears ERR.
- B0 held 0 through SYNC for 50 cycles → BUSY=1, MASK unchanged, ACK=0. Raise B0 → MASK updates and ACK=1 on the same edge.
- nRST pulsed at BUILD idx=7 → state IDLE, MASK=0, E=0, no ACK; KSKIP change during BUILD (4→12) without reset → result still 0x8888.

Source files
------------

// File: rtl/skip_sched.sv
// Configuration controller for the cycle-skipping clock ring: takes a skip count over a
// 4-phase REQ/ACK handshake, spreads it evenly over LEN slots and applies it at slot 0.
module skip_sched #(
    parameter int LEN = 16,
    parameter int KW  = 5
) (
    input  logic           iCLK,
    input  logic           nRST,
    input  logic           REQ,
    input  logic [KW-1:0]  KSKIP,
    input  logic           B0,
    output logic [LEN-1:0] MASK,
    output logic           E,
    output logic           ACK,
    output logic           BUSY,
    output logic           ERR
);

    localparam int IW = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] lastIdx = IW'(LEN - 1);
    localparam logic [KW-1:0] kMax    = KW'(LEN - 1);
    localparam logic [KW:0]   lenW    = (KW+1)'(LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        SYNC  = 2'd2,
        ACKW  = 2'd3
    } state_t;

    state_t         state, stateNxt;
    logic [KW-1:0]  kReg, kNxt;
    logic [KW-1:0]  acc, accNxt;
    logic [IW-1:0]  idx, idxNxt;
    logic [LEN-1:0] shadow, shadowNxt;
    logic [LEN-1:0] maskNxt;
    logic           eNxt, ackNxt, errNxt;
    logic [KW:0]    step;

    // One Bresenham step: returns {skip bit, new accumulator}. acc < LEN and k < LEN,
    // so the KW+1 bit sum cannot overflow and one subtraction always brings it back in range.
    function automatic logic [KW:0] spreadStep(input logic [KW-1:0] a, input logic [KW-1:0] kk);
        logic [KW:0] s;
        s = {1'b0, a} + {1'b0, kk};
        if (s >= lenW)
            return {1'b1, KW'(s - lenW)};
        else
            return {1'b0, KW'(s)};
    endfunction

    assign step = spreadStep(acc, kReg);
    assign BUSY = (state != IDLE);

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            kReg   <= '0;
            acc    <= '0;
            idx    <= '0;
            shadow <= '0;
            MASK   <= '0;
            E      <= 1'b0;
            ACK    <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= stateNxt;
            kReg   <= kNxt;
            acc    <= accNxt;
            idx    <= idxNxt;
            shadow <= shadowNxt;
            MASK   <= maskNxt;
            E      <= eNxt;
            ACK    <= ackNxt;
            ERR    <= errNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        kNxt      = kReg;
        accNxt    = acc;
        idxNxt    = idx;
        shadowNxt = shadow;
        maskNxt   = MASK;
        eNxt      = E;
        ackNxt    = ACK;
        errNxt    = ERR;

        unique case (state)
            IDLE: begin
                if (REQ) begin
                    if (KSKIP > kMax) begin
                        // Reject leaves MASK and E alone; only the handshake and ERR move.
                        ackNxt   = 1'b1;
                        errNxt   = 1'b1;
                        stateNxt = ACKW;
                    end else begin
                        kNxt     = KSKIP;
                        errNxt   = 1'b0;
                        accNxt   = '0;
                        idxNxt   = '0;
                        stateNxt = BUILD;
                    end
                end
            end
            BUILD: begin
                shadowNxt[idx] = step[KW];
                accNxt         = step[KW-1:0];
                if (idx == lastIdx) begin
                    stateNxt = SYNC;
                end else begin
                    idxNxt = idx + 1'b1;
                end
            end
            SYNC: begin
                // B0 only moves on negedge, so the ring is parked in slot 0 across this edge;
                // slot 0 is unskipped in both masks, making the swap glitch-free.
                if (B0) begin
                    maskNxt  = shadow;
                    eNxt     = 1'b1;
                    ackNxt   = 1'b1;
                    stateNxt = ACKW;
                end
            end
            ACKW: begin
                if (!REQ) begin
                    ackNxt   = 1'b0;
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_skip_sched.sv
// Bench for skip_sched: table of skip counts with expected masks fed through a scoreboard,
// plus hand sequences for SYNC stalls, KSKIP changes during build and mid-build reset.
module tb_skip_sched;

    localparam int LEN = 16;
    localparam int KW  = 5;

    logic           iCLK = 1'b0;
    logic           nRST = 1'b0;
    logic           REQ  = 1'b0;
    logic [KW-1:0]  KSKIP = '0;
    logic           B0;
    logic [LEN-1:0] MASK;
    logic           E, ACK, BUSY, ERR;

    int checks = 0;
    int errors = 0;

    // Ring model: slot counter advancing on negedge; b0Mode 0 = follow ring, 1 = hold 0, 2 = hold 1.
    int   slot   = 0;
    int   b0Mode = 0;
    assign B0 = (b0Mode == 0) ? (slot == 0) : (b0Mode == 2);

    always #5 iCLK = ~iCLK;
    always @(negedge iCLK) slot <= (slot + 1) % LEN;

    skip_sched #(.LEN(LEN), .KW(KW)) dut (
        .iCLK (iCLK),
        .nRST (nRST),
        .REQ  (REQ),
        .KSKIP(KSKIP),
        .B0   (B0),
        .MASK (MASK),
        .E    (E),
        .ACK  (ACK),
        .BUSY (BUSY),
        .ERR  (ERR)
    );

    typedef struct {
        logic [KW-1:0]  k;
        logic [LEN-1:0] mask;
        logic           err;
    } vec_t;

    typedef struct {
        logic [KW-1:0]  k;
        logic [LEN-1:0] mask;
        logic           err;
        logic           e;
    } exp_t;

    exp_t sb[$];
    logic curE = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic startReq(input logic [KW-1:0] k, input logic [LEN-1:0] m, input logic err);
        exp_t x;
        x.k = k; x.mask = m; x.err = err; x.e = err ? curE : 1'b1;
        sb.push_back(x);
        @(posedge iCLK); #1;
        REQ   = 1'b1;
        KSKIP = k;
    endtask

    task automatic waitAck(output int cyc);
        cyc = 0;
        while (!ACK && cyc < 300) begin
            @(posedge iCLK); #1;
            cyc++;
        end
        if (!ACK) chk("ack_timeout", 32'(ACK), 32'd1);
    endtask

    task automatic finishReq(output int cyc);
        exp_t x;
        waitAck(cyc);
        x = sb.pop_front();
        chk("mask",  32'(MASK), 32'(x.mask));
        chk("err",   32'(ERR),  32'(x.err));
        chk("e",     32'(E),    32'(x.e));
        chk("busy_ack", 32'(BUSY), 32'd1);
        if (!x.err) chk("popcount", 32'($countones(MASK)), 32'(x.k));
        curE = x.e;
        // ACK must hold until REQ drops, then fall on the next edge.
        @(posedge iCLK); #1;
        chk("ack_hold", 32'(ACK), 32'd1);
        REQ = 1'b0;
        @(posedge iCLK); #1;
        chk("ack_drop",  32'(ACK),  32'd0);
        chk("busy_idle", 32'(BUSY), 32'd0);
    endtask

    vec_t vecs[9];
    int   cyc;

    initial begin
        vecs[0] = '{5'd4,  16'h8888, 1'b0};
        vecs[1] = '{5'd8,  16'hAAAA, 1'b0};
        vecs[2] = '{5'd15, 16'hFFFE, 1'b0};
        vecs[3] = '{5'd0,  16'h0000, 1'b0};
        vecs[4] = '{5'd4,  16'h8888, 1'b0};
        vecs[5] = '{5'd16, 16'h8888, 1'b1};
        vecs[6] = '{5'd2,  16'h8080, 1'b0};
        vecs[7] = '{5'd31, 16'h8080, 1'b1};
        vecs[8] = '{5'd1,  16'h8000, 1'b0};

        #2;
        chk("rst_mask", 32'(MASK), 32'd0);
        chk("rst_e",    32'(E),    32'd0);
        chk("rst_ack",  32'(ACK),  32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err",  32'(ERR),  32'd0);
        repeat (3) @(posedge iCLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 9; i++) begin
            startReq(vecs[i].k, vecs[i].mask, vecs[i].err);
            finishReq(cyc);
            if (i == 0) begin
                // REQ raised before edge T0; apply no earlier than T(LEN+1), within one revolution after.
                chk("latency_min", 32'(cyc >= LEN + 2), 32'd1);
                chk("latency_max", 32'(cyc <= 2 * LEN + 2), 32'd1);
            end
        end

        // KSKIP change while building must be ignored.
        startReq(5'd4, 16'h8888, 1'b0);
        repeat (3) @(posedge iCLK);
        #1 KSKIP = 5'd12;
        finishReq(cyc);

        // B0 held low: controller must wait in SYNC indefinitely.
        @(negedge iCLK); b0Mode = 1;
        startReq(5'd8, 16'hAAAA, 1'b0);
        repeat (LEN + 50) @(posedge iCLK);
        #1;
        chk("sync_busy", 32'(BUSY), 32'd1);
        chk("sync_ack",  32'(ACK),  32'd0);
        chk("sync_mask", 32'(MASK), 32'h8888);
        @(negedge iCLK); b0Mode = 2;
        @(posedge iCLK); #1;
        chk("sync_apply_ack",  32'(ACK),  32'd1);
        chk("sync_apply_mask", 32'(MASK), 32'hAAAA);
        @(negedge iCLK); b0Mode = 0;
        finishReq(cyc);

        // Asynchronous reset in the middle of BUILD (idx=7).
        @(posedge iCLK); #1;
        REQ = 1'b1; KSKIP = 5'd4;
        repeat (8) @(posedge iCLK);
        #2 nRST = 1'b0;
        #1;
        chk("arst_mask", 32'(MASK), 32'd0);
        chk("arst_e",    32'(E),    32'd0);
        chk("arst_ack",  32'(ACK),  32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_err",  32'(ERR),  32'd0);
        REQ = 1'b0;
        @(negedge iCLK); nRST = 1'b1;
        curE = 1'b0;
        repeat (LEN + 4) @(posedge iCLK);
        #1;
        chk("post_rst_ack",  32'(ACK),  32'd0);
        chk("post_rst_mask", 32'(MASK), 32'd0);

        // Recovery after reset.
        startReq(5'd4, 16'h8888, 1'b0);
        finishReq(cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
